// File: rtl/pulse_gen.sv
// ============================================================================
// Module      : pulse_gen
// Description : Detector-like ADC sample source: linear rise, exponential
//               decay, pile-up of overlapping triggers, fixed baseline.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pulse_gen #(
    parameter int SIZE_ADC_DATA = 12,
    parameter int AMP_WIDTH     = 12,
    parameter int ACC_FRAC      = 8,
    parameter int RISE_SHIFT    = 2,
    parameter int DECAY_SHIFT   = 5,
    parameter int BASELINE      = 100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     trig_valid,
    input  logic [AMP_WIDTH-1:0]     trig_amp,
    output logic                     trig_ready,
    output logic [SIZE_ADC_DATA-1:0] output_data,
    output logic                     busy,
    output logic                     sat
);

    localparam int ACC_W  = AMP_WIDTH + ACC_FRAC + 1;
    localparam int STEP_W = AMP_WIDTH + ACC_FRAC;
    localparam int RCNT_W = RISE_SHIFT + 1;
    localparam int INT_W  = ACC_W - ACC_FRAC;

    localparam logic [RCNT_W-1:0] RISE_LEN   = RCNT_W'(2 ** RISE_SHIFT);
    localparam logic [31:0]       SAMPLE_MAX = 32'((2 ** SIZE_ADC_DATA) - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RISE  = 2'd1;
    localparam logic [1:0] S_DECAY = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic [RCNT_W-1:0]        rcnt_q, rcnt_d;
    logic [SIZE_ADC_DATA-1:0] output_data_q, output_data_d;
    logic                     busy_q, busy_d;
    logic                     sat_q, sat_d;

    logic                     accept;
    logic [STEP_W-1:0]        new_step;
    logic [ACC_W:0]           rise_sum;
    logic                     rise_ovf;
    logic [ACC_W-1:0]         decay_next;
    logic [INT_W-1:0]         acc_int;
    logic [31:0]              sample_sum;
    logic                     sample_clamp;

    assign trig_ready = enable && (state_q != S_RISE);
    assign accept     = trig_valid && trig_ready;

    // Low amplitude bits fall off here; peak is step * 2^RISE_SHIFT, not amp.
    assign new_step   = (STEP_W'(trig_amp) << ACC_FRAC) >> RISE_SHIFT;
    assign rise_sum   = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(step_q);
    assign rise_ovf   = rise_sum[ACC_W];
    assign decay_next = acc_q - (acc_q >> DECAY_SHIFT);
    assign acc_int    = acc_q[ACC_W-1:ACC_FRAC];

    assign sample_sum   = 32'(BASELINE) + 32'(acc_int);
    assign sample_clamp = sample_sum > SAMPLE_MAX;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        rcnt_d  = rcnt_q;
        sat_d   = sat_q | sample_clamp;

        case (state_q)
            S_IDLE: begin
                acc_d = '0;
                if (accept) begin
                    step_d  = new_step;
                    rcnt_d  = RISE_LEN;
                    state_d = S_RISE;
                end
            end
            S_RISE: begin
                acc_d  = rise_ovf ? '1 : rise_sum[ACC_W-1:0];
                sat_d  = sat_q | sample_clamp | rise_ovf;
                rcnt_d = rcnt_q - RCNT_W'(1);
                if (rcnt_q == RCNT_W'(1)) begin
                    state_d = S_DECAY;
                end
            end
            S_DECAY: begin
                // Pile-up: the new pulse starts from the untouched residue.
                if (accept) begin
                    step_d  = new_step;
                    rcnt_d  = RISE_LEN;
                    state_d = S_RISE;
                end else if (acc_int == '0) begin
                    acc_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = decay_next;
                end
            end
            default: begin
                acc_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        output_data_d = sample_clamp ? '1 : sample_sum[SIZE_ADC_DATA-1:0];
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            step_q        <= '0;
            rcnt_q        <= '0;
            output_data_q <= '0;
            busy_q        <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            step_q        <= step_d;
            rcnt_q        <= rcnt_d;
            output_data_q <= output_data_d;
            busy_q        <= busy_d;
            sat_q         <= sat_d;
        end
    end

    assign output_data = output_data_q;
    assign busy        = busy_q;
    assign sat         = sat_q;

endmodule

`default_nettype wire

// File: doc/pulse_gen.md
# pulse_gen

Synthesizes detector-like ADC sample streams: on each accepted trigger it produces a pulse with a linear rise and an exponential decay, riding on a fixed baseline. It sits in front of the shaping filters in the filter test chain, as their data source. Its `output_data` connects directly to a filter's `input_data`. Overlapping triggers pile up the way real detector pulses do, so the filters can be exercised on-chip without an ADC.

## Interface
Parameters:
- SIZE_ADC_DATA, 12: output sample width (unsigned).
- AMP_WIDTH, 12: trigger amplitude width.
- ACC_FRAC, 8: fractional bits in the internal accumulator.
- RISE_SHIFT, 2: rise lasts 2^RISE_SHIFT cycles.
- DECAY_SHIFT, 5: per-cycle decay factor (1 - 2^-DECAY_SHIFT), so tau ≈ 32 clk.
- BASELINE, 100: constant offset added to every sample.

Ports (reset: reset, asynchronous, active-low; clock: clk):
- clk  in  1  sample clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low.
- enable  in  1  allows new triggers to be accepted.
- trig_valid  in  1  trigger request.
- trig_amp  in  AMP_WIDTH  pulse amplitude in LSBs, sampled at handshake.
- trig_ready  out  1  combinational: enable && state != RISE.
- output_data  out  SIZE_ADC_DATA  registered sample.
- busy  out  1  registered: state != IDLE.
- sat  out  1  sticky saturation flag; cleared only by reset.

## Operation
- Accumulator `acc` is unsigned, AMP_WIDTH+ACC_FRAC+1 bits. The integer part is acc >> ACC_FRAC.
- Handshake: a trigger is accepted on an edge where trig_valid && trig_ready. trig_amp is sampled on that edge.
- FSM states: IDLE, RISE, DECAY.
- IDLE: acc = 0.
  - Accept → load step = (trig_amp << ACC_FRAC) >> RISE_SHIFT.
  - Load rcnt = 2^RISE_SHIFT and go to RISE.
  - acc is unchanged on the accept edge.
- RISE: each cycle, acc += step and rcnt -= 1. On the edge where rcnt goes 1→0, go to DECAY.
  - trig_ready = 0 in RISE; triggers offered during RISE wait.
- DECAY: each cycle, acc <= acc - (acc >> DECAY_SHIFT).
  - If the integer part of acc is 0 at the edge, then set acc <= 0 and go to IDLE. This rule also prevents decay stalling at small residues.
- Accept while in DECAY (pile-up): load step and rcnt and go to RISE. acc keeps its current value and no decay is applied on that edge. The new pulse adds on top of the residue.
- Accept takes priority over the DECAY→IDLE transition on the same edge.
- Overflow of acc + step clamps acc to all-ones and sets sat.
- Output: output_data <= min(BASELINE + int(acc), 2^SIZE_ADC_DATA - 1). Clamping sets sat.
- enable = 0: no new accepts; a pulse already running completes normally.
- Truncation: step drops the low bits of amp, so peak int = residue + (step*2^RISE_SHIFT >> ACC_FRAC).

## Timing
- Reset values: output_data = 0, busy = 0, sat = 0, acc = 0, state = IDLE.
  - output_data shows BASELINE from the first edge after reset release.
- Reset asserted mid-pulse: everything clears immediately (asynchronously); the pulse is lost.
- Latency: accept at edge E0.
  - acc additions occur at E1..E(2^RISE_SHIFT).
  - output_data lags acc by one edge, so the first rise sample appears after E2 and the peak after E(2^RISE_SHIFT + 1).
- State is DECAY after E(2^RISE_SHIFT); the first decay is applied at the next edge.
- Throughput: one sample per clock; at most one accept per 2^RISE_SHIFT + 1 cycles.
- busy falls on the edge where acc clears.

## Test plan
- Reset, then idle with enable = 1 → output_data = 100 every cycle; busy = 0; sat = 0.
- Accept amp = 400 at E0 (defaults).
  - output_data after E2..E5 = 200, 300, 400, 500.
  - Then 487 and 475 on the next two edges.
  - busy returns to 0 within 256 cycles after E0, after which output_data = 100.
- Pile-up: amp = 400, then a second amp = 200 accepted 20 cycles after the first peak → the new peak equals the residue integer part + 200 + 100. trig_ready is low for the 4 RISE cycles.
- Saturation: amp = 4095 → output_data clamps at 4095; sat = 1 and stays 1 after the pulse decays, until reset.
- Trigger held valid through the whole of RISE, and enable = 0 during a pulse → no extra accepts in either case; the held trigger is accepted on the first DECAY cycle with enable = 1.
- Reset pulsed mid-decay → output_data = 0 and busy = 0 immediately; output_data = 100 one edge after release.
